// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_acc_pkg;

    // Accumulate beats, resolve the redundant pair chunk by chunk, then hold the result.
    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Widest accumulator the extension helper supports.
    localparam int MAX_W = 256;

    // Extend an in_w-bit operand (zero-padded in data) to MAX_W bits.
    function automatic logic [MAX_W-1:0] ext_operand(input logic [MAX_W-1:0] data,
                                                     input int              in_w,
                                                     input logic            is_signed);
        logic [MAX_W-1:0] r;
        logic [7:0]       msb;
        logic             fill;
        msb  = 8'(in_w - 1);
        fill = is_signed & data[msb];
        r    = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < in_w) ? data[i] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_row.sv
// One row of W full adders: reduces three W-bit vectors to a sum/carry pair.
module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_s,
    output logic [W-1:0] o_c
);

    // Carry vector is shifted up one place; nothing feeds bit 0.
    assign o_c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_fa
            assign o_s[i] = i_x[i] ^ i_y[i] ^ i_z[i];
            // The carry out of the top bit falls off: arithmetic is modulo 2^W.
            if (i < W - 1) begin : g_cy
                assign o_c[i+1] = (i_x[i] & i_y[i]) | (i_x[i] & i_z[i]) | (i_y[i] & i_z[i]);
            end
        end
    endgenerate

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: carry-save running total, one operand
// per cycle, chunked carry-propagate resolve, result on a valid/ready port.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int W      = 64,
    parameter int IN_W   = 64,
    parameter int SIGNED = 0,
    parameter int CHUNK  = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int NCH   = W / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (IN_W > W) begin : g_bad_in_w
            $error("csa_stream_accumulator: IN_W must not exceed W");
        end
        if ((W % CHUNK) != 0) begin : g_bad_chunk
            $error("csa_stream_accumulator: W must be a multiple of CHUNK");
        end
        if (W > MAX_W) begin : g_bad_w
            $error("csa_stream_accumulator: W exceeds package MAX_W");
        end
    endgenerate

    state_t             r_state;
    logic [W-1:0]       r_s;
    logic [W-1:0]       r_c;
    logic [W-1:0]       r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_cin;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [MAX_W-1:0]   w_ext_full;
    logic [W-1:0]       w_ext;
    logic [W-1:0]       w_s;
    logic [W-1:0]       w_c;
    logic [CHUNK-1:0]   w_cs;
    logic [CHUNK-1:0]   w_cc;
    logic [CHUNK:0]     w_add;

    // Operand extension is pure wiring; only the low W bits are used.
    assign w_ext_full = ext_operand(MAX_W'(in_data), IN_W, SIGNED != 0);
    assign w_ext      = w_ext_full[W-1:0];

    csa_row #(.W(W)) u_row (
        .i_x (r_s),
        .i_y (r_c),
        .i_z (w_ext),
        .o_s (w_s),
        .o_c (w_c)
    );

    // Current resolve chunk: S + C + carry-in from the chunk below.
    assign w_cs  = r_s[int'(r_idx)*CHUNK +: CHUNK];
    assign w_cc  = r_c[int'(r_idx)*CHUNK +: CHUNK];
    assign w_add = {1'b0, w_cs} + {1'b0, w_cc} + (CHUNK+1)'(r_cin);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_res;
    assign out_count = r_cnt;

    // Control FSM plus all datapath registers; reset drops any partial total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACC;
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_cin       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid && r_in_ready) begin
                        r_s <= w_s;
                        r_c <= w_c;
                        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        if (in_last) begin
                            r_state    <= RESOLVE;
                            r_idx      <= '0;
                            r_cin      <= 1'b0;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_res[int'(r_idx)*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
                    r_cin <= w_add[CHUNK];
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NCH - 1)) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_s         <= '0;
                        r_c         <= '0;
                        r_cnt       <= '0;
                        r_state     <= ACC;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ACC;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
